// File: rtl/ethernet_ctrl_pkg.sv
// Shared types and constants for the Ethernet link bring-up controller.
// State encodings, counter widths and status-register bit positions.
package ethernet_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_DEBOUNCE  = 3'd3,
    ST_UP        = 3'd4,
    ST_FAIL      = 3'd5
  } link_state_e;

  localparam int unsigned LOST_W = 16;
  localparam logic [LOST_W-1:0] LOST_SAT = 16'hFFFF;

  localparam int unsigned STS_STATE_LSB  = 0;
  localparam int unsigned STS_STATE_W    = 3;
  localparam int unsigned STS_LINK_UP    = 3;
  localparam int unsigned STS_LINK_FAIL  = 4;
  localparam int unsigned STS_RETRY_LSB  = 8;

  // Bits needed to hold 0..maxv, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a,
                                       input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ethernet_link_timer.sv
// Loadable saturating up-counter with a terminal-count compare.
// tc_o stays high once the count reaches or passes term_i.
module ethernet_link_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; hold at all-ones so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q >= term_i);

endmodule

// File: rtl/ethernet_link_bringup_ctrl.sv
// Link bring-up sequencer: reset, wait for lock, debounce, retry.
// Macro ETH_LINK_RECOVERY_EN: re-bring-up on lock loss instead of FAIL.
module ethernet_link_bringup_ctrl
  import ethernet_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT    = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES     = 7,
  localparam int unsigned RC_W = cnt_w(MAX_RETRIES)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              enable,
  input  logic              rx_block_lock,
  output logic              gt_reset,
  output logic              link_up,
  output logic              link_fail,
  output logic [RC_W-1:0]   retry_count,
  output logic [LOST_W-1:0] link_lost_count,
  output logic [2:0]        state
);

  localparam int unsigned TMR_W = cnt_w(max2(RESET_CYCLES, LOCK_TIMEOUT));
  localparam int unsigned DEB_W = cnt_w(DEBOUNCE_CYCLES);

  link_state_e       state_q, state_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              gt_q, up_q, fail_q;

  logic              tmr_clr, tmr_en, tmr_tc;
  logic [TMR_W-1:0]  tmr_term;
  logic              deb_clr, deb_en, deb_tc;

  // Reset timer and lock timer share one counter.
  assign tmr_term = (state_q == ST_RESET) ? TMR_W'(RESET_CYCLES - 1)
                                          : TMR_W'(LOCK_TIMEOUT - 1);

  ethernet_link_timer #(.W(TMR_W)) u_tmr (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

  ethernet_link_timer #(.W(DEB_W)) u_deb (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .clr_i  (deb_clr),
    .en_i   (deb_en),
    .term_i (DEB_W'(DEBOUNCE_CYCLES - 1)),
    .tc_o   (deb_tc)
  );

  // Next-state, timer control and counter updates.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    deb_clr = 1'b0;
    deb_en  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
      tmr_clr = 1'b1;
      deb_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          tmr_clr = 1'b1;
        end
        ST_RESET: begin
          if (tmr_tc) begin
            state_d = ST_WAIT_LOCK;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          tmr_en = 1'b1;
          if (rx_block_lock) begin
            state_d = ST_DEBOUNCE;
            deb_clr = 1'b1;
          end else if (tmr_tc) begin
            tmr_clr = 1'b1;
            if (retry_q == RC_W'(MAX_RETRIES)) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET;
              retry_d = retry_q + RC_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          tmr_en = 1'b1;
          if (rx_block_lock && deb_tc) begin
            state_d = ST_UP;
          end else if (tmr_tc) begin
            tmr_clr = 1'b1;
            if (retry_q == RC_W'(MAX_RETRIES)) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET;
              retry_d = retry_q + RC_W'(1);
            end
          end else if (!rx_block_lock) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            deb_en = 1'b1;
          end
        end
        ST_UP: begin
          if (!rx_block_lock) begin
            if (lost_q != LOST_SAT)
              lost_d = lost_q + LOST_W'(1);
`ifdef ETH_LINK_RECOVERY_EN
            state_d = ST_RESET;
            retry_d = '0;
            tmr_clr = 1'b1;
`else
            state_d = ST_FAIL;
`endif
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
          deb_clr = 1'b1;
        end
      endcase
    end
  end

  // State, counters and outputs, all decoded from the next state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      lost_q  <= '0;
      gt_q    <= 1'b1;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      gt_q    <= (state_d == ST_IDLE) || (state_d == ST_RESET) ||
                 (state_d == ST_FAIL);
      up_q    <= (state_d == ST_UP);
      fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign gt_reset        = gt_q;
  assign link_up         = up_q;
  assign link_fail       = fail_q;
  assign retry_count     = retry_q;
  assign link_lost_count = lost_q;
  assign state           = state_q;

endmodule

// File: tb/tb_ethernet_link_bringup_ctrl.sv
// Directed bench for ethernet_link_bringup_ctrl.
// Small parameters: reset 4, timeout 20, debounce 8, two retries.
module tb_ethernet_link_bringup_ctrl;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned DC = 8;
  localparam int unsigned MR = 2;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        enable;
  logic        rx_block_lock;
  logic        gt_reset;
  logic        link_up;
  logic        link_fail;
  logic [1:0]  retry_count;
  logic [15:0] link_lost_count;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  ethernet_link_bringup_ctrl #(
    .RESET_CYCLES    (RC),
    .LOCK_TIMEOUT    (LT),
    .DEBOUNCE_CYCLES (DC),
    .MAX_RETRIES     (MR)
  ) dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .enable          (enable),
    .rx_block_lock   (rx_block_lock),
    .gt_reset        (gt_reset),
    .link_up         (link_up),
    .link_fail       (link_fail),
    .retry_count     (retry_count),
    .link_lost_count (link_lost_count),
    .state           (state)
  );

  always #5 ACLK = ~ACLK;

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    ARESET = 1'b1;
    enable = 1'b0;
    rx_block_lock = 1'b0;
    step(3);
    ARESET = 1'b0;
    step(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_gt", 32'(gt_reset), 1);
    chk("rst_up", 32'(link_up), 0);
    chk("rst_fail", 32'(link_fail), 0);
    chk("rst_retry", 32'(retry_count), 0);
    chk("rst_lost", 32'(link_lost_count), 0);

    // Happy path: lock high throughout.
    enable = 1'b1;
    rx_block_lock = 1'b1;
    step(1);
    chk("hp_reset_st", 32'(state), 1);
    step(3);
    chk("hp_gt_c4", 32'(gt_reset), 1);
    step(1);
    chk("hp_gt_c5", 32'(gt_reset), 0);
    chk("hp_wait_st", 32'(state), 2);
    step(1);
    chk("hp_deb_st", 32'(state), 3);
    step(7);
    chk("hp_up_c13", 32'(link_up), 0);
    step(1);
    chk("hp_up_c14", 32'(link_up), 1);
    chk("hp_up_st", 32'(state), 4);
    chk("hp_retry", 32'(retry_count), 0);

    // Lock loss while up.
    rx_block_lock = 1'b0;
    step(1);
    chk("loss_lost", 32'(link_lost_count), 1);
    chk("loss_up", 32'(link_up), 0);
`ifdef ETH_LINK_RECOVERY_EN
    chk("loss_st", 32'(state), 1);
    chk("loss_gt", 32'(gt_reset), 1);
`else
    chk("loss_st", 32'(state), 5);
    chk("loss_fail", 32'(link_fail), 1);
`endif
    enable = 1'b0;
    step(1);
    chk("loss_idle", 32'(state), 0);
    chk("loss_fail_clr", 32'(link_fail), 0);
    chk("loss_lost_kept", 32'(link_lost_count), 1);

    // Bouncing lock: high, one low cycle, high again.
    enable = 1'b1;
    step(5);
    chk("bn_wait", 32'(state), 2);
    rx_block_lock = 1'b1;
    step(5);
    chk("bn_deb1", 32'(state), 3);
    rx_block_lock = 1'b0;
    step(1);
    chk("bn_back_wait", 32'(state), 2);
    rx_block_lock = 1'b1;
    step(1);
    chk("bn_deb2", 32'(state), 3);
    step(7);
    chk("bn_deb2_end", 32'(state), 3);
    step(1);
    chk("bn_up", 32'(state), 4);
    chk("bn_retry", 32'(retry_count), 0);
    enable = 1'b0;
    rx_block_lock = 1'b0;
    step(1);
    chk("bn_idle", 32'(state), 0);

    // Lock rises on the exact timeout cycle.
    enable = 1'b1;
    step(24);
    chk("sim_wait", 32'(state), 2);
    rx_block_lock = 1'b1;
    step(1);
    chk("sim_deb", 32'(state), 3);
    chk("sim_retry", 32'(retry_count), 0);
    step(1);
    chk("sim_to_st", 32'(state), 1);
    chk("sim_to_retry", 32'(retry_count), 1);
    enable = 1'b0;
    rx_block_lock = 1'b0;
    step(1);
    chk("sim_idle_retry", 32'(retry_count), 0);

    // Retry exhaustion with lock stuck low.
    enable = 1'b1;
    step(24);
    chk("ex_a1_wait", 32'(state), 2);
    step(1);
    chk("ex_a2_st", 32'(state), 1);
    chk("ex_a2_retry", 32'(retry_count), 1);
    step(24);
    chk("ex_a3_retry", 32'(retry_count), 2);
    step(23);
    chk("ex_a3_wait", 32'(state), 2);
    chk("ex_a3_nofail", 32'(link_fail), 0);
    step(1);
    chk("ex_fail_st", 32'(state), 5);
    chk("ex_fail", 32'(link_fail), 1);
    chk("ex_gt", 32'(gt_reset), 1);
    chk("ex_retry", 32'(retry_count), 2);
    step(5);
    chk("ex_sticky", 32'(link_fail), 1);
    enable = 1'b0;
    step(1);
    chk("ex_idle", 32'(state), 0);
    chk("ex_fail_clr", 32'(link_fail), 0);
    chk("ex_retry_clr", 32'(retry_count), 0);

    // enable dropped during RESET.
    enable = 1'b1;
    step(2);
    chk("ab_reset", 32'(state), 1);
    enable = 1'b0;
    step(1);
    chk("ab_idle", 32'(state), 0);
    chk("ab_gt", 32'(gt_reset), 1);

    // ARESET during DEBOUNCE.
    enable = 1'b1;
    rx_block_lock = 1'b1;
    step(6);
    chk("ar_deb", 32'(state), 3);
    ARESET = 1'b1;
    step(1);
    chk("ar_state", 32'(state), 0);
    chk("ar_gt", 32'(gt_reset), 1);
    chk("ar_up", 32'(link_up), 0);
    chk("ar_fail", 32'(link_fail), 0);
    chk("ar_retry", 32'(retry_count), 0);
    chk("ar_lost", 32'(link_lost_count), 0);
    ARESET = 1'b0;
    enable = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
